checkpointed_free_list: RTL and testbench

CHECKPOINTED_FREE_LIST -- requirements
Module: checkpointed_free_list

---
 rtl/checkpointed_free_list.sv | 84 ++++++++
 tb/tb_checkpointed_free_list.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/checkpointed_free_list.sv
// Free list of physical register tags for rename: a circular FIFO whose head
// pointer can be snapshotted into checkpoint columns and rolled back on a flush.
module checkpointed_free_list #(
   parameter int NUM_PHYS_REGS      = 64,
   parameter int NUM_ARCH_REGS      = 32,
   parameter int CHECKPOINT_COLUMNS = 4,
   localparam int DEPTH  = NUM_PHYS_REGS - NUM_ARCH_REGS,
   localparam int TAG_W  = $clog2(NUM_PHYS_REGS),
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CKPT_W = $clog2(CHECKPOINT_COLUMNS)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              dequeue_req,
   output logic              dequeue_valid,
   output logic [TAG_W-1:0]  dequeue_tag,
   input  logic              enqueue_valid,
   input  logic [TAG_W-1:0]  enqueue_tag,
   input  logic              save_valid,
   input  logic [CKPT_W-1:0] save_column,
   input  logic              restore_valid,
   input  logic [CKPT_W-1:0] restore_column,
   output logic [PTR_W:0]    count,
   output logic              empty,
   output logic              full,
   output logic              overflow_err
);

   localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);

   logic [TAG_W-1:0] mem [DEPTH];
   logic [PTR_W:0]   head;
   logic [PTR_W:0]   tail;
   logic [PTR_W:0]   ckpt_head [CHECKPOINT_COLUMNS];

   logic             deq_fire;
   logic             enq_fire;
   logic [PTR_W:0]   head_after;

   // Handshake: dequeue_valid is the "ready" of the free list; a tag is taken when
   // dequeue_req && dequeue_valid && !restore_valid, and is presented the same cycle.
   // Enqueue has no back-pressure: enqueue_valid while full drops the tag and raises
   // overflow_err for one cycle.
   assign count         = tail - head;
   assign empty         = (count == '0);
   assign full          = (count == CNT_DEPTH);
   assign dequeue_valid = !empty;
   assign dequeue_tag   = mem[head[PTR_W-1:0]];

   assign deq_fire   = dequeue_req && !empty && !restore_valid;
   assign enq_fire   = enqueue_valid && !full;
   assign head_after = deq_fire ? head + PTR_ONE : head;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         head         <= '0;
         tail         <= {1'b1, {PTR_W{1'b0}}};
         overflow_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= TAG_W'(NUM_ARCH_REGS + i);
         end
         for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
            ckpt_head[c] <= '0;
         end
      end else begin
         overflow_err <= enqueue_valid && full;
         // Restore only moves head; tail and storage are left to the enqueue path.
         if (restore_valid) begin
            head <= ckpt_head[restore_column];
         end else begin
            head <= head_after;
            if (save_valid) begin
               ckpt_head[save_column] <= head_after;
            end
         end
         if (enq_fire) begin
            mem[tail[PTR_W-1:0]] <= enqueue_tag;
            tail                 <= tail + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_checkpointed_free_list.sv
// Directed bench for checkpointed_free_list: a monitor checks every accepted
// dequeue against an expected-tag queue; status outputs are checked after edges.
module tb_checkpointed_free_list;

   logic       CLK;
   logic       nRST;
   logic       dequeue_req;
   logic       dequeue_valid;
   logic [5:0] dequeue_tag;
   logic       enqueue_valid;
   logic [5:0] enqueue_tag;
   logic       save_valid;
   logic [1:0] save_column;
   logic       restore_valid;
   logic [1:0] restore_column;
   logic [5:0] count;
   logic       empty;
   logic       full;
   logic       overflow_err;

   int checks = 0;
   int errors = 0;
   logic [5:0] exp_q[$];

   checkpointed_free_list dut (
      .CLK(CLK), .nRST(nRST),
      .dequeue_req(dequeue_req), .dequeue_valid(dequeue_valid), .dequeue_tag(dequeue_tag),
      .enqueue_valid(enqueue_valid), .enqueue_tag(enqueue_tag),
      .save_valid(save_valid), .save_column(save_column),
      .restore_valid(restore_valid), .restore_column(restore_column),
      .count(count), .empty(empty), .full(full), .overflow_err(overflow_err)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t, required earlier", $time);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   // monitor: every accepted dequeue must match the next expected tag
   always @(negedge CLK) begin
      if (nRST && dequeue_req && dequeue_valid && !restore_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL deq_unexpected: got tag %0d, no dequeue expected", dequeue_tag);
         end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            if (dequeue_tag !== e) begin
               errors++;
               $display("FAIL deq_tag: got %0d, expected %0d", dequeue_tag, e);
            end
         end
      end
   end

   // driver tasks
   task automatic idle_inputs();
      dequeue_req    = 1'b0;
      enqueue_valid  = 1'b0;
      enqueue_tag    = '0;
      save_valid     = 1'b0;
      save_column    = '0;
      restore_valid  = 1'b0;
      restore_column = '0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      idle_inputs();
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   // One cycle of stimulus; exp_tag >= 0 means this dequeue is expected to be accepted.
   task automatic drive(input logic deq, input logic enq, input int etag,
                        input logic sv, input int scol, input logic rs, input int rcol,
                        input int exp_tag);
      if (exp_tag >= 0) exp_q.push_back(6'(exp_tag));
      dequeue_req    = deq;
      enqueue_valid  = enq;
      enqueue_tag    = 6'(etag);
      save_valid     = sv;
      save_column    = 2'(scol);
      restore_valid  = rs;
      restore_column = 2'(rcol);
      @(posedge CLK);
      #1;
      idle_inputs();
   endtask

   task automatic deq_n(input int n, input int first_tag);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, first_tag + i);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic status(input string name, input int cnt, input int emp, input int ful, input int ovf);
      chk({name, "_count"}, int'(count), cnt);
      chk({name, "_empty"}, int'(empty), emp);
      chk({name, "_full"},  int'(full),  ful);
      chk({name, "_ovf"},   int'(overflow_err), ovf);
   endtask

   initial begin
      idle_inputs();
      do_reset();

      // reset state
      status("reset", 32, 0, 1, 0);
      chk("reset_valid", int'(dequeue_valid), 1);
      chk("reset_tag", int'(dequeue_tag), 32);

      // enqueue while full is dropped with a one-cycle error pulse
      drive(0, 1, 5, 0, 0, 0, 0, -1);
      status("ovf_pulse", 32, 0, 1, 1);
      chk("ovf_tag", int'(dequeue_tag), 32);
      drive(0, 0, 0, 0, 0, 0, 0, -1);
      status("ovf_clear", 32, 0, 1, 0);

      // three dequeues, count steps down
      deq_n(1, 32); status("deq1", 31, 0, 0, 0);
      deq_n(1, 33); status("deq2", 30, 0, 0, 0);
      deq_n(1, 34); status("deq3", 29, 0, 0, 0);

      // drain the rest
      deq_n(29, 35);
      status("drained", 0, 1, 0, 0);
      chk("drained_valid", int'(dequeue_valid), 0);
      drive(1, 0, 0, 0, 0, 0, 0, -1);
      status("deq_empty", 0, 1, 0, 0);

      // refill across the tail wrap and drain again
      drive(0, 1, 5, 0, 0, 0, 0, -1);
      drive(0, 1, 6, 0, 0, 0, 0, -1);
      drive(0, 1, 7, 0, 0, 0, 0, -1);
      status("refill", 3, 0, 0, 0);
      chk("refill_tag", int'(dequeue_tag), 5);
      deq_n(2, 5);
      status("redrain2", 1, 0, 0, 0);
      deq_n(1, 7);
      status("redrain3", 0, 1, 0, 0);

      // reset mid-operation overrides every request in one edge
      nRST          = 1'b0;
      dequeue_req   = 1'b1;
      enqueue_valid = 1'b1;
      enqueue_tag   = 6'd9;
      save_valid    = 1'b1;
      save_column   = 2'd1;
      @(posedge CLK);
      #1;
      idle_inputs();
      nRST = 1'b1;
      status("midreset", 32, 0, 1, 0);
      chk("midreset_tag", int'(dequeue_tag), 32);

      // save col 2 after 5 dequeues, take 3 more, restore with a dequeue_req pending
      deq_n(5, 32);
      drive(0, 0, 0, 1, 2, 0, 0, -1);
      deq_n(3, 37);
      status("pre_restore", 24, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 2, -1);
      status("restore2", 27, 0, 0, 0);
      chk("restore2_tag", int'(dequeue_tag), 37);
      deq_n(1, 37);
      status("after_restore2", 26, 0, 0, 0);

      // count=10, then dequeue+enqueue+save in one cycle
      do_reset();
      deq_n(22, 32);
      status("count10", 10, 0, 0, 0);
      drive(1, 1, 9, 1, 1, 0, 0, 54);
      status("deq_enq_save", 10, 0, 0, 0);
      deq_n(2, 55);
      status("pre_restore1", 8, 0, 0, 0);
      // saved head was 23 (count 10 at restore time), plus this cycle's enqueue
      drive(0, 1, 11, 0, 0, 1, 1, -1);
      status("restore1_enq", 11, 0, 0, 0);
      chk("restore1_tag", int'(dequeue_tag), 55);
      deq_n(1, 55);

      // save and restore together: restore wins; never-saved column yields head 0
      do_reset();
      deq_n(4, 32);
      drive(0, 0, 0, 1, 0, 1, 3, -1);
      status("restore3", 32, 0, 1, 0);
      chk("restore3_tag", int'(dequeue_tag), 32);
      deq_n(2, 32);
      drive(0, 0, 0, 0, 0, 1, 0, -1);
      status("restore0", 32, 0, 1, 0);
      chk("restore0_tag", int'(dequeue_tag), 32);

      repeat (2) @(posedge CLK);
      #1;
      chk("exp_q_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
